clm_mod_p_decoder: RTL and testbench
====================================

# clm_mod_p_decoder

Sequential output decoder for the CLM AES core: converts a 16-element redundant state (each element an (8+d)-bit polynomial) back to a plain 128-bit AES state. Each element is reduced modulo the base polynomial P by bit-serial long division, then mapped through Linv to a standard AES byte. It is the inverse of the input encoding stage and sits between the round datapath (MOD_P / PREP_OUTPUT stages) and the ciphertext output.

## Interface
- d, default 7 (types::d), redundancy degree; element width r = 8+d; legal 1..15
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- drdy_i  input  1  start strobe; sampled only while idle
- in  input  state_vec_t (16 x (8+d))  redundant state; element in[row][col]
- P  input  base_poly_t [0:8]  base polynomial; bit 0 = x^8 coefficient, bit 8 = x^0
- Linv  input  mm_matrix_t  8x8 GF(2) output map
- out  output  aes_state_t  decoded state, out[row][col][0:7]
- drdy_o  output  1  one-cycle pulse, out valid from this cycle
- busy  output  1  high while a decode is in progress

## Operation
- Bit order: state_t bit i = coefficient of x^(7+d-i); residue/byte bit j = coefficient of x^(7-j).
- States: IDLE, REDUCE, MAP.
- IDLE: busy=0. drdy_i=1 at an edge -> latch in, P, Linv into internal registers; load work = in[0][0]; step=0; k=0; -> REDUCE. Inputs may change after this edge.
- REDUCE, one division step per cycle: if work[0]=1, XOR P[1:8] into work[1:8]; then shift work left one bit (zero-fill). P[0] is ignored and treated as 1. At the edge where step = d-1, -> MAP; otherwise step+1.
- After d steps, residue = work[0:7].
- MAP, one cycle: buf[k] = Linv * residue over GF(2), i.e. byte[i] = XOR_j (Linv[i][j] & residue[j]). Element order is k = 4*row + col, written to buf[row][col].
  - k<15: k+1; load work = in_latched[next]; step=0; -> REDUCE.
  - k=15: copy full buffer (including byte 15) to out; drdy_o=1; -> IDLE.
- out updates only at completion, all 128 bits together, and holds until the next completion.
- drdy_i while busy=1 is ignored; the request is not queued.
- Reset (async, any state): state=IDLE, out=0, drdy_o=0, busy=0, internal registers 0. An aborted decode never produces drdy_o.

## Timing
- E0 = edge sampling drdy_i=1 in IDLE.
- Byte k is stored at edge E((k+1)(d+1)).
- drdy_o is high for exactly the cycle after edge E(16(d+1)). With d=7 that is E128.
- busy is registered: high from E0 until E(16(d+1)).
- Back-to-back: drdy_i high during the drdy_o cycle is accepted at the next edge (state is already IDLE), giving zero dead cycles.
- Throughput: one decode per 16(d+1)+1 cycles.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Identity decode, d=7, P=9'b1_0001_1011, Linv=identity, all elements 15'h00AB -> after 128 edges drdy_o pulses once; every out byte = 8'hAB.
- Pure reduction: element 15'h0100 (x^8) -> byte 8'h1B. Element (x*P) XOR 8'h55 = 15'h0263 -> 8'h55. Element 15'h7FFF -> byte equals software reference of the mod-P remainder. Mix these across the 16 positions to check row/col ordering.
- Linv map: Linv = bit-reversal permutation, element 15'h0001 -> 8'h80. Linv all-zero -> all bytes 8'h00.
- Handshake: drdy_i pulsed again at cycles 10 and 127 -> ignored, single drdy_o at E128. drdy_i held high through the drdy_o cycle -> second decode completes at E257 with new data. Changing in after E0 does not affect the result.
- Reset mid-op: assert rst low at cycle 50 -> out=0, busy=0, drdy_o=0 immediately; no drdy_o follows. A new decode after release completes normally in 128 cycles.
- Parameter sweep d=1 and d=15, random in/P(P[0]=1)/Linv -> out matches reference model; drdy_o at E(16(d+1)) = E32 and E256 respectively.

Source files
------------

// File: rtl/clm_mod_p_decoder.sv
// rtl/clm_mod_p_decoder.sv - bit-serial mod-P reduction and Linv output map for the CLM AES state
module clm_mod_p_decoder #(
    parameter int d = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        drdy_i,
    input  logic [3:0][3:0][7+d:0]      in,
    input  logic [8:0]                  P,
    input  logic [7:0][7:0]             Linv,
    output logic [3:0][3:0][7:0]        out,
    output logic                        drdy_o,
    output logic                        busy
);

    localparam int R = 8 + d;
    localparam logic [3:0] LAST_STEP = 4'(d - 1);

    typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_MAP} state_t;

    state_t                 state, state_nx;
    logic [3:0][3:0][R-1:0] in_q;
    logic [7:0]             p_q;
    logic [7:0][7:0]        linv_q;
    logic [R-1:0]           work;
    logic [R-1:0]           work_shift;
    logic [R-2:0]           pterm;
    logic [3:0]             step;
    logic [3:0]             k;
    logic [3:0]             k_nx;
    logic [7:0]             residue;
    logic [7:0]             mapped;
    logic [3:0][3:0][7:0]   buf_q, buf_nx;
    logic                   step_last, k_last;
    logic                   load_start, do_step, do_map, done;
    logic                   unused_p_lead;

    // The x^8 coefficient of P is implicitly 1, so the input bit is not needed.
    assign unused_p_lead = P[8];

    // P's low coefficients aligned under the leading work bit (x^(7+d)).
    assign pterm      = (R-1)'(p_q) << (d - 1);
    assign work_shift = {work[R-2:0] ^ (work[R-1] ? pterm : '0), 1'b0};
    assign residue    = work[R-1:d];
    assign step_last  = (step == LAST_STEP);
    assign k_last     = (k == 4'd15);
    assign k_nx       = k + 4'd1;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state logic: d reduce steps then one map cycle per element.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (drdy_i) state_nx = S_REDUCE;
            S_REDUCE: if (step_last) state_nx = S_MAP;
            S_MAP:    state_nx = k_last ? S_IDLE : S_REDUCE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Per-state datapath controls.
    always_comb begin
        load_start = (state == S_IDLE) && drdy_i;
        do_step    = (state == S_REDUCE);
        do_map     = (state == S_MAP);
        done       = do_map && k_last;
    end

    // GF(2) matrix-vector product: each output bit is the parity of a masked row.
    always_comb begin
        mapped = '0;
        for (int a = 0; a < 8; a++) mapped[a] = ^(linv_q[a] & residue);
    end

    // Buffer image with the current element's byte merged in.
    always_comb begin
        buf_nx = buf_q;
        buf_nx[k[3:2]][k[1:0]] = mapped;
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_q   <= '0;
            p_q    <= '0;
            linv_q <= '0;
            work   <= '0;
            step   <= '0;
            k      <= '0;
            buf_q  <= '0;
            out    <= '0;
            drdy_o <= 1'b0;
            busy   <= 1'b0;
        end else begin
            if (load_start) begin
                in_q   <= in;
                p_q    <= P[7:0];
                linv_q <= Linv;
                work   <= in[0][0];
                step   <= '0;
                k      <= '0;
            end
            if (do_step) begin
                work <= work_shift;
                if (!step_last) step <= step + 4'd1;
            end
            if (do_map) begin
                buf_q <= buf_nx;
                if (k_last) begin
                    out <= buf_nx;
                end else begin
                    k    <= k_nx;
                    work <= in_q[k_nx[3:2]][k_nx[1:0]];
                    step <= '0;
                end
            end
            drdy_o <= done;
            busy   <= (state_nx != S_IDLE);
        end
    end

endmodule

// File: tb/tb_clm_mod_p_decoder.sv
// tb/tb_clm_mod_p_decoder.sv - directed and swept checks of clm_mod_p_decoder
module tb_clm_mod_p_decoder;

    logic clk;
    logic rst;
    logic [2:0] di_v;
    logic [2:0] dr_v;
    logic [2:0] busy_v;

    logic [3:0][3:0][14:0] in7;
    logic [3:0][3:0][8:0]  in1;
    logic [3:0][3:0][22:0] in15;
    logic [8:0]            p7, p1, p15;
    logic [7:0][7:0]       l7, l1, l15;
    logic [3:0][3:0][7:0]  out7, out1, out15;

    int checks = 0;
    int errors = 0;

    clm_mod_p_decoder #(.d(7)) dut7 (
        .clk(clk), .rst(rst), .drdy_i(di_v[0]), .in(in7), .P(p7), .Linv(l7),
        .out(out7), .drdy_o(dr_v[0]), .busy(busy_v[0]));
    clm_mod_p_decoder #(.d(1)) dut1 (
        .clk(clk), .rst(rst), .drdy_i(di_v[1]), .in(in1), .P(p1), .Linv(l1),
        .out(out1), .drdy_o(dr_v[1]), .busy(busy_v[1]));
    clm_mod_p_decoder #(.d(15)) dut15 (
        .clk(clk), .rst(rst), .drdy_i(di_v[2]), .in(in15), .P(p15), .Linv(l15),
        .out(out15), .drdy_o(dr_v[2]), .busy(busy_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [22:0] e, input int dd,
                                            input logic [8:0] p, input logic [7:0][7:0] L);
        logic [22:0] w;
        logic [7:0]  res;
        logic [7:0]  b;
        w = e;
        for (int i = 7 + dd; i >= 8; i--)
            if (w[i]) w = w ^ (23'({1'b1, p[7:0]}) << (i - 8));
        res = w[7:0];
        for (int a = 0; a < 8; a++) b[a] = ^(L[a] & res);
        return b;
    endfunction

    // Start a decode on one instance, scramble its inputs after E0, wait for drdy_o.
    task automatic run_dut(input int which, input int budget, output int lat);
        lat = -1;
        @(negedge clk);
        di_v[which] = 1'b1;
        @(posedge clk);
        #1;
        di_v[which] = 1'b0;
        chk("busy_after_e0", 128'(busy_v[which]), 128'(1));
        case (which)
            0:       begin in7  = ~in7;  p7  = ~p7;  l7  = ~l7;  end
            1:       begin in1  = ~in1;  p1  = ~p1;  l1  = ~l1;  end
            default: begin in15 = ~in15; p15 = ~p15; l15 = ~l15; end
        endcase
        for (int n = 1; n <= budget && lat < 0; n++) begin
            @(posedge clk);
            #1;
            if (dr_v[which]) lat = n;
        end
    endtask

    logic [7:0][7:0]      id_m, br_m;
    logic [3:0][3:0][7:0] exp_s, exp_b;
    logic [7:0]           ref7fff;
    int lat, cnt, first, second;

    initial begin
        rst  = 1'b0;
        di_v = '0;
        in7 = '0; in1 = '0; in15 = '0;
        p7 = '0; p1 = '0; p15 = '0;
        l7 = '0; l1 = '0; l15 = '0;
        for (int a = 0; a < 8; a++) begin
            id_m[a] = 8'(1 << a);
            br_m[a] = 8'(1 << (7 - a));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", out7, '0);
        chk("reset_drdy", 128'(dr_v), '0);
        chk("reset_busy", 128'(busy_v), '0);
        @(negedge clk);
        rst = 1'b1;

        // Identity decode: every element 0x00AB -> 0xAB.
        for (int k = 0; k < 16; k++) in7[k/4][k%4] = 15'h00AB;
        p7 = 9'b1_0001_1011;
        l7 = id_m;
        run_dut(0, 200, lat);
        chk("ident_latency", 128'(lat), 128'(128));
        chk("ident_out", out7, {16{8'hAB}});
        @(posedge clk);
        #1;
        chk("ident_drdy_single", 128'(dr_v[0]), 128'(0));
        chk("ident_busy_done", 128'(busy_v[0]), 128'(0));

        // Pure reduction mixed across positions to check row/col ordering.
        ref7fff = ref_byte(23'h7FFF, 7, 9'h11B, id_m);
        for (int k = 0; k < 16; k++) begin
            case (k % 4)
                0: begin in7[k/4][k%4] = 15'h0100; exp_s[k/4][k%4] = 8'h1B;  end
                1: begin in7[k/4][k%4] = 15'h0263; exp_s[k/4][k%4] = 8'h55;  end
                2: begin in7[k/4][k%4] = 15'h7FFF; exp_s[k/4][k%4] = ref7fff; end
                default: begin in7[k/4][k%4] = 15'h00AB; exp_s[k/4][k%4] = 8'hAB; end
            endcase
        end
        in7[1][2] = 15'h0100; exp_s[1][2] = 8'h1B;
        p7 = 9'h11B;
        l7 = id_m;
        run_dut(0, 200, lat);
        chk("mixed_latency", 128'(lat), 128'(128));
        chk("mixed_out", out7, exp_s);

        // Bit-reversal Linv.
        for (int k = 0; k < 16; k++) in7[k/4][k%4] = 15'h0001;
        p7 = 9'h11B;
        l7 = br_m;
        run_dut(0, 200, lat);
        chk("bitrev_out", out7, {16{8'h80}});

        // All-zero Linv.
        for (int k = 0; k < 16; k++) in7[k/4][k%4] = 15'h7FFF - 15'(k);
        p7 = 9'h11B;
        l7 = '0;
        run_dut(0, 200, lat);
        chk("zero_linv_out", out7, '0);

        // drdy_i while busy at cycles 10 and 127 is ignored.
        for (int k = 0; k < 16; k++) in7[k/4][k%4] = 15'h00AB;
        p7 = 9'h11B;
        l7 = id_m;
        @(negedge clk);
        di_v[0] = 1'b1;
        @(posedge clk);
        #1;
        di_v[0] = 1'b0;
        cnt = 0; first = -1;
        for (int n = 1; n <= 140; n++) begin
            @(negedge clk);
            di_v[0] = (n == 10 || n == 127);
            @(posedge clk);
            #1;
            if (dr_v[0]) begin
                cnt++;
                if (first < 0) first = n;
            end
        end
        di_v[0] = 1'b0;
        chk("ignore_pulse_count", 128'(cnt), 128'(1));
        chk("ignore_pulse_edge", 128'(first), 128'(128));
        chk("ignore_out", out7, {16{8'hAB}});

        // Back-to-back: drdy_i held through the drdy_o cycle.
        for (int k = 0; k < 16; k++) in7[k/4][k%4] = 15'h0100;
        p7 = 9'h11B;
        l7 = id_m;
        @(negedge clk);
        di_v[0] = 1'b1;
        @(posedge clk);
        #1;
        di_v[0] = 1'b0;
        cnt = 0; first = -1; second = -1;
        for (int n = 1; n <= 270; n++) begin
            @(negedge clk);
            if (n == 2) in7 = '1;
            if (n == 129) for (int k = 0; k < 16; k++) in7[k/4][k%4] = 15'h0263;
            if (n == 130) in7 = '0;
            di_v[0] = (n == 128 || n == 129);
            @(posedge clk);
            #1;
            if (dr_v[0]) begin
                cnt++;
                if (first < 0) first = n;
                else second = n;
            end
            if (n == 128) chk("b2b_first_out", out7, {16{8'h1B}});
        end
        di_v[0] = 1'b0;
        chk("b2b_pulse_count", 128'(cnt), 128'(2));
        chk("b2b_first_edge", 128'(first), 128'(128));
        chk("b2b_second_edge", 128'(second), 128'(257));
        chk("b2b_second_out", out7, {16{8'h55}});

        // Reset mid-operation.
        for (int k = 0; k < 16; k++) in7[k/4][k%4] = 15'h00AB;
        @(negedge clk);
        di_v[0] = 1'b1;
        @(posedge clk);
        #1;
        di_v[0] = 1'b0;
        repeat (50) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_out", out7, '0);
        chk("midrst_busy", 128'(busy_v[0]), 128'(0));
        chk("midrst_drdy", 128'(dr_v[0]), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (dr_v[0]) cnt++;
        end
        chk("midrst_no_drdy", 128'(cnt), 128'(0));
        for (int k = 0; k < 16; k++) in7[k/4][k%4] = 15'h0263;
        p7 = 9'h11B;
        l7 = id_m;
        run_dut(0, 200, lat);
        chk("postrst_latency", 128'(lat), 128'(128));
        chk("postrst_out", out7, {16{8'h55}});

        // Random sweep for d=1 and d=15 against the long-division model.
        for (int it = 0; it < 2; it++) begin
            p1 = {1'b1, 8'($urandom)};
            for (int a = 0; a < 8; a++) l1[a] = 8'($urandom);
            for (int k = 0; k < 16; k++) begin
                in1[k/4][k%4] = 9'($urandom);
                exp_b[k/4][k%4] = ref_byte(23'(in1[k/4][k%4]), 1, p1, l1);
            end
            run_dut(1, 100, lat);
            chk("d1_latency", 128'(lat), 128'(32));
            chk("d1_out", out1, exp_b);

            p15 = {1'b1, 8'($urandom)};
            for (int a = 0; a < 8; a++) l15[a] = 8'($urandom);
            for (int k = 0; k < 16; k++) begin
                in15[k/4][k%4] = 23'($urandom);
                exp_b[k/4][k%4] = ref_byte(in15[k/4][k%4], 15, p15, l15);
            end
            run_dut(2, 400, lat);
            chk("d15_latency", 128'(lat), 128'(256));
            chk("d15_out", out15, exp_b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
